// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined SIMD vector ALU.
package alu_pkg;
  localparam int LANE_W = 8;

  typedef enum logic [3:0] {
    AND    = 4'd0,
    OR     = 4'd1,
    XOR    = 4'd2,
    ADD    = 4'd3,
    SEQ    = 4'd4,
    SNE    = 4'd5,
    SUB    = 4'd6,
    AVGADD = 4'd7,
    AVGSUB = 4'd8,
    MAX    = 4'd9,
    MIN    = 4'd10,
    ADDS   = 4'd11,
    SUBS   = 4'd12,
    RSV13  = 4'd13,
    RSV14  = 4'd14,
    RSV15  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {P8 = 2'd0, P16 = 2'd1, P32 = 2'd2, P64 = 2'd3} prec_e;

  // Lane is the lowest lane of an element of 2^prec lanes.
  function automatic bit elem_base(input logic [1:0] prec, input int lane);
    return (lane & ((32'sd1 <<< prec) - 1)) == 0;
  endfunction
endpackage

// File: rtl/vec_alu_pipe_if.sv
// Operand/result handshake bundle between register-read, vector ALU and writeback.
interface vec_alu_pipe_if #(parameter int BITS = 64);
  logic              in_valid;
  logic              in_ready;
  logic [BITS-1:0]   a;
  logic [BITS-1:0]   b;
  logic [3:0]        opcode;
  logic [1:0]        precision;
  logic              is_signed;
  logic              out_valid;
  logic              out_ready;
  logic [BITS-1:0]   result;
  logic [BITS/8-1:0] flag;

  modport master (
    output in_valid, a, b, opcode, precision, is_signed, out_ready,
    input  in_ready, out_valid, result, flag
  );

  modport slave (
    input  in_valid, a, b, opcode, precision, is_signed, out_ready,
    output in_ready, out_valid, result, flag
  );
endinterface

// File: rtl/seg_adder.sv
// Segmented adder: 8-bit Kogge-Stone lanes whose carry chain breaks at element bases.
module seg_adder
  import alu_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic [BITS-1:0]        a,
  input  logic [BITS-1:0]        b_eff,
  input  logic                   sub,
  input  logic [1:0]             prec,
  output logic [BITS-1:0]        sum,
  output logic [BITS/LANE_W-1:0] cout
);
  localparam int NL = BITS / LANE_W;

  function automatic logic [8:0] ks_add8(input logic [7:0] x, input logic [7:0] y,
                                         input logic cin);
    logic [7:0] g, p, p0, c;
    g  = x & y;
    p0 = x ^ y;
    p  = p0;
    for (int d = 1; d < 8; d = d * 2) begin
      for (int i = 7; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    c[0] = cin;
    for (int i = 1; i < 8; i++) c[i] = g[i-1] | (p[i-1] & cin);
    return {g[7] | (p[7] & cin), p0 ^ c};
  endfunction

  logic       cy;
  logic       lane_cin;
  logic [8:0] lane_sum;

  always_comb begin
    sum      = '0;
    cout     = '0;
    cy       = 1'b0;
    lane_cin = 1'b0;
    lane_sum = '0;
    for (int i = 0; i < NL; i++) begin
      lane_cin = elem_base(prec, i) ? sub : cy;
      lane_sum = ks_add8(a[i*LANE_W +: LANE_W], b_eff[i*LANE_W +: LANE_W], lane_cin);
      sum[i*LANE_W +: LANE_W] = lane_sum[7:0];
      cout[i] = lane_sum[8];
      cy      = lane_sum[8];
    end
  end
endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage SIMD integer ALU with valid/ready on both sides; one segmented adder
// serves arithmetic, compare, averaging and saturation.
module vec_alu_pipe
  import alu_pkg::*;
#(
  parameter int BITS = 64,
  parameter int LANE = 8
) (
  input logic           clk,
  input logic           rst,
  vec_alu_pipe_if.slave bus
);
  localparam int NL = BITS / LANE;

  logic              vld_p1, vld_p2, ready, adv2;
  logic [BITS-1:0]   a_p1, b_p1;
  opcode_e           op_p1;
  logic [1:0]        prec_p1;
  logic              sgn_p1;
  logic [BITS-1:0]   result_p2;
  logic [NL-1:0]     flag_p2;

  logic              sub;
  logic [BITS-1:0]   b_eff, sum, sum_sh, res_c;
  logic [NL-1:0]     cout, lane_eq, flg_c;

  function automatic logic is_sub(input opcode_e op);
    return op inside {SUB, AVGSUB, SUBS, MAX, MIN};
  endfunction

  // Clamp value for one lane of a saturated element.
  function automatic logic [7:0] sat_byte(input logic sgn, input logic subtract,
                                          input logic neg, input logic top);
    if (!sgn)    return subtract ? 8'h00 : 8'hFF;
    else if (neg) return top ? 8'h80 : 8'h00;
    else          return top ? 8'h7F : 8'hFF;
  endfunction

  assign adv2          = !vld_p2 || bus.out_ready;
  assign ready         = !vld_p1 || !vld_p2 || bus.out_ready;
  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_p2;
  assign bus.result    = result_p2;
  assign bus.flag      = flag_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ready) vld_p1 <= bus.in_valid;
      if (adv2)  vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (bus.in_valid && ready) begin
      a_p1    <= bus.a;
      b_p1    <= bus.b;
      op_p1   <= opcode_e'(bus.opcode);
      prec_p1 <= bus.precision;
      sgn_p1  <= bus.is_signed;
    end
  end

  assign sub    = is_sub(op_p1);
  assign b_eff  = sub ? ~b_p1 : b_p1;
  assign sum_sh = {1'b0, sum[BITS-1:1]};

  seg_adder #(.BITS(BITS)) u_add (
    .a     (a_p1),
    .b_eff (b_eff),
    .sub   (sub),
    .prec  (prec_p1),
    .sum   (sum),
    .cout  (cout)
  );

  always_comb begin
    lane_eq = '0;
    for (int i = 0; i < NL; i++)
      lane_eq[i] = (a_p1[i*LANE +: LANE] == b_p1[i*LANE +: LANE]);
  end

  // Every lane looks up its element's top lane for carry and sign information.
  always_comb begin
    int         span, base, top;
    logic       eq, c, am, bm, em, sm, lt, ext, nxt, clamp, f, is_top;
    logic [7:0] ab, bb, sb, rb;
    res_c = '0;
    flg_c = '0;
    for (int i = 0; i < NL; i++) begin
      span   = 32'sd1 <<< prec_p1;
      base   = i & ~(span - 1);
      top    = base + span - 1;
      is_top = (i == top);
      eq     = 1'b1;
      for (int j = 0; j < NL; j++)
        if (j >= base && j <= top) eq = eq & lane_eq[j];
      c   = cout[top];
      am  = a_p1[top*LANE + 7];
      bm  = b_p1[top*LANE + 7];
      em  = b_eff[top*LANE + 7];
      sm  = sum[top*LANE + 7];
      ab  = a_p1[i*LANE +: LANE];
      bb  = b_p1[i*LANE +: LANE];
      sb  = sum[i*LANE +: LANE];
      lt  = (sgn_p1 && (am ^ bm)) ? am : !c;
      ext = (sgn_p1 ? am : 1'b0) ^ (sgn_p1 ? em : sub) ^ c;
      nxt = is_top ? ext : sum_sh[i*LANE + 7];
      clamp = sgn_p1 ? ((am == em) && (sm != am)) : (sub ? !c : c);
      f  = 1'b0;
      rb = 8'h00;
      case (op_p1)
        AND:            rb = ab & bb;
        OR:             rb = ab | bb;
        XOR:            rb = ab ^ bb;
        ADD:            begin rb = sb; f = c;  end
        SUB:            begin rb = sb; f = !c; end
        SEQ:            rb = {7'b0, elem_base(prec_p1, i) & eq};
        SNE:            rb = {7'b0, elem_base(prec_p1, i) & !eq};
        AVGADD, AVGSUB: rb = {nxt, sb[7:1]};
        MAX:            rb = lt ? bb : ab;
        MIN:            rb = (!lt && !eq) ? bb : ab;
        ADDS, SUBS: begin
          rb = clamp ? sat_byte(sgn_p1, sub, am, is_top) : sb;
          f  = clamp;
        end
        default:        rb = 8'h00;
      endcase
      res_c[i*LANE +: LANE] = rb;
      flg_c[i] = is_top & f;
    end
  end

  // ---- stage 2: result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p2 <= '0;
      flag_p2   <= '0;
    end else if (adv2 && vld_p1) begin
      result_p2 <= res_c;
      flag_p2   <= flg_c;
    end
  end
endmodule

// File: tb/tb_vec_alu_pipe.sv
// Randomized and directed bench for vec_alu_pipe against an element-level arithmetic model.
module tb_vec_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vec_alu_pipe_if #(.BITS(64)) bus ();

  vec_alu_pipe #(.BITS(64), .LANE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Element-wise reference using wide exact integer arithmetic.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] op, input logic [1:0] prec,
                                input logic sgn, output logic [63:0] res,
                                output logic [7:0] flg);
    int E, ne;
    logic [71:0] mask, ua, ub, ur;
    logic signed [71:0] va, vb, r, hi, lo;
    logic f;
    E = 8 << prec;
    ne = 64 / E;
    res = '0;
    flg = '0;
    mask = (72'd1 << E) - 72'd1;
    for (int k = 0; k < ne; k++) begin
      ua = ({8'b0, a} >> (k * E)) & mask;
      ub = ({8'b0, b} >> (k * E)) & mask;
      va = $signed(ua);
      vb = $signed(ub);
      if (sgn && ua[E-1]) va = va - $signed(72'd1 << E);
      if (sgn && ub[E-1]) vb = vb - $signed(72'd1 << E);
      hi = sgn ? $signed((72'd1 << (E - 1)) - 72'd1) : $signed(mask);
      lo = sgn ? -$signed(72'd1 << (E - 1)) : 72'sd0;
      f = 1'b0;
      ur = '0;
      r = '0;
      case (op)
        4'd0: ur = ua & ub;
        4'd1: ur = ua | ub;
        4'd2: ur = ua ^ ub;
        4'd3: begin ur = ua + ub; f = ur[E]; end
        4'd6: begin ur = ua - ub; f = (ua < ub); end
        4'd4: ur = {71'b0, ua == ub};
        4'd5: ur = {71'b0, ua != ub};
        4'd7: begin r = va + vb; ur = r >>> 1; end
        4'd8: begin r = va - vb; ur = r >>> 1; end
        4'd9:  ur = (va >= vb) ? ua : ub;
        4'd10: ur = (va <= vb) ? ua : ub;
        4'd11, 4'd12: begin
          r = (op == 4'd11) ? va + vb : va - vb;
          if (r > hi) begin r = hi; f = 1'b1; end
          else if (r < lo) begin r = lo; f = 1'b1; end
          ur = r;
        end
        default: ur = '0;
      endcase
      res = res | 64'((ur & mask) << (k * E));
      flg[(k * E) / 8 + E / 8 - 1] = f;
    end
  endfunction

  function automatic logic [63:0] rnd_vec();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom % 8)
        0: v[i*8 +: 8] = 8'h00;
        1: v[i*8 +: 8] = 8'hFF;
        2: v[i*8 +: 8] = 8'h80;
        3: v[i*8 +: 8] = 8'h7F;
        default: v[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drive_rand();
    bus.a         = rnd_vec();
    bus.b         = rnd_vec();
    bus.opcode    = 4'($urandom_range(0, 15));
    bus.precision = 2'($urandom_range(0, 3));
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  // One isolated transaction; lat counts negedges from acceptance to out_valid (-1 = none).
  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [1:0] prec, input logic sgn,
                         output logic [63:0] res, output logic [7:0] flg, output int lat);
    lat = -1;
    res = '0;
    flg = '0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.opcode = op; bus.precision = prec; bus.is_signed = sgn;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.out_valid === 1'b1) begin
        res = bus.result;
        flg = bus.flag;
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.opcode = '0; bus.precision = '0; bus.is_signed = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++;
    if (bus.result !== 64'h0 || bus.flag !== 8'h0)
      begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", bus.result, bus.flag); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [63:0] a, b;
    logic [3:0]  op;
    logic [1:0]  prec;
    logic        sgn;
    logic [63:0] r;
    logic [7:0]  f;
  } dcase_t;

  task automatic test_directed();
    logic [63:0] r;
    logic [7:0]  f;
    int          lat;
    dcase_t dc [14] = '{
      '{64'hFF,   64'h01,   ADD,    2'd0, 1'b0, 64'h0,    8'h01},
      '{64'hFF,   64'h01,   ADD,    2'd3, 1'b0, 64'h100,  8'h00},
      '{64'h80,   64'h01,   SUBS,   2'd0, 1'b1, 64'h80,   8'h01},
      '{64'h00,   64'h01,   SUBS,   2'd0, 1'b0, 64'h00,   8'h01},
      '{64'hFFFF, 64'h0001, MAX,    2'd1, 1'b1, 64'h0001, 8'h00},
      '{64'hFFFF, 64'h0001, MAX,    2'd1, 1'b0, 64'hFFFF, 8'h00},
      '{64'hFFFF, 64'h0001, MIN,    2'd1, 1'b1, 64'hFFFF, 8'h00},
      '{64'hFFFF, 64'h0001, MIN,    2'd1, 1'b0, 64'h0001, 8'h00},
      '{64'hFF,   64'h01,   AVGADD, 2'd0, 1'b0, 64'h80,   8'h00},
      '{64'h80,   64'hFF,   AVGADD, 2'd0, 1'b1, 64'hBF,   8'h00},
      '{64'h00,   64'h02,   AVGSUB, 2'd0, 1'b0, 64'hFF,   8'h00},
      '{64'h00,   64'h01,   SUB,    2'd0, 1'b0, 64'hFF,   8'h01},
      '{64'h12345678, 64'h12345678, SEQ, 2'd2, 1'b0, 64'h0000_0001_0000_0001, 8'h00},
      '{64'hFFFF_FFFF, 64'h1, RSV13, 2'd0, 1'b0, 64'h0, 8'h00}
    };
    for (int i = 0; i < 14; i++) begin
      run_one(dc[i].a, dc[i].b, dc[i].op, dc[i].prec, dc[i].sgn, r, f, lat);
      n_tests++;
      if (lat != 1) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 1", i, lat); end
      n_tests++;
      if (r !== dc[i].r || f !== dc[i].f)
        begin n_fail++; $display("FAIL directed[%0d]: got %h/%h want %h/%h", i, r, f, dc[i].r, dc[i].f); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, r, er;
    logic [7:0]  f, ef;
    logic [3:0]  op;
    logic [1:0]  prec;
    logic        sgn;
    int          lat;
    for (int i = 0; i < 150; i++) begin
      a = rnd_vec(); b = rnd_vec();
      op = 4'($urandom_range(0, 15)); prec = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
      run_one(a, b, op, prec, sgn, r, f, lat);
      model(a, b, op, prec, sgn, er, ef);
      n_tests++;
      if (lat < 0) begin n_fail++; $display("FAIL random[%0d]: no output, want %h/%h", i, er, ef); end
      else if (r !== er || f !== ef)
        begin n_fail++; $display("FAIL random[%0d] op=%0d p=%0d s=%b a=%h b=%h: got %h/%h want %h/%h",
                                 i, op, prec, sgn, a, b, r, f, er, ef); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q_r[$], er, hold_r;
    logic [7:0]  q_f[$], ef, hold_f;
    int  sent = 0, got = 0;
    bit  pending = 0, stall = 0;
    for (int cyc = 0; cyc < 2000 && got < 60; cyc++) begin
      @(negedge clk);
      if (!pending) begin
        if (sent < 60) begin drive_rand(); bus.in_valid = 1'b1; sent++; end
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom % 3) != 0;
      #1;
      if (bus.out_valid === 1'b1) begin
        if (stall) begin
          n_tests++;
          if (bus.result !== hold_r || bus.flag !== hold_f)
            begin n_fail++; $display("FAIL b2b_hold: got %h/%h want %h/%h", bus.result, bus.flag, hold_r, hold_f); end
        end
        if (bus.out_ready) begin
          n_tests++;
          if (q_r.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got %h want none", bus.result); end
          else begin
            er = q_r.pop_front(); ef = q_f.pop_front();
            if (bus.result !== er || bus.flag !== ef)
              begin n_fail++; $display("FAIL b2b[%0d]: got %h/%h want %h/%h", got, bus.result, bus.flag, er, ef); end
          end
          got++;
          stall = 0;
        end else begin
          stall = 1; hold_r = bus.result; hold_f = bus.flag;
        end
      end else stall = 0;
      if (bus.in_valid && bus.in_ready) begin
        model(bus.a, bus.b, bus.opcode, bus.precision, bus.is_signed, er, ef);
        q_r.push_back(er); q_f.push_back(ef);
        pending = 0;
      end else pending = bus.in_valid;
    end
    n_tests++;
    if (got != 60) begin n_fail++; $display("FAIL b2b_count: got %0d want 60", got); end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [63:0] q_r[$], er, hold_r;
    logic [7:0]  q_f[$], ef, hold_f;
    int  nacc = 0, outs = 0, last_c = 0;
    bit  load_next = 1, seen = 0, gap_ok = 1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (load_next) begin
        if (nacc < 3) begin drive_rand(); bus.in_valid = 1'b1; end else bus.in_valid = 1'b0;
        load_next = 0;
      end
      #1;
      if (bus.out_valid === 1'b1) begin
        if (seen) begin
          n_tests++;
          if (bus.result !== hold_r || bus.flag !== hold_f)
            begin n_fail++; $display("FAIL bp_hold: got %h/%h want %h/%h", bus.result, bus.flag, hold_r, hold_f); end
        end
        hold_r = bus.result; hold_f = bus.flag; seen = 1;
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.a, bus.b, bus.opcode, bus.precision, bus.is_signed, er, ef);
        q_r.push_back(er); q_f.push_back(ef);
        nacc++; load_next = 1;
      end
    end
    n_tests++;
    if (nacc != 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
      begin n_fail++; $display("FAIL bp_stall: got acc=%0d in_ready=%b out_valid=%b want 2/0/1",
                               nacc, bus.in_ready, bus.out_valid); end
    for (int c = 0; c < 20 && outs < 3; c++) begin
      @(negedge clk);
      if (load_next) begin
        if (nacc < 3) begin drive_rand(); bus.in_valid = 1'b1; end else bus.in_valid = 1'b0;
        load_next = 0;
      end
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid === 1'b1) begin
        n_tests++;
        er = (q_r.size() > 0) ? q_r.pop_front() : 64'hx;
        ef = (q_f.size() > 0) ? q_f.pop_front() : 8'hx;
        if (bus.result !== er || bus.flag !== ef)
          begin n_fail++; $display("FAIL bp_order[%0d]: got %h/%h want %h/%h", outs, bus.result, bus.flag, er, ef); end
        if (outs > 0 && c != last_c + 1) gap_ok = 0;
        last_c = c;
        outs++;
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.a, bus.b, bus.opcode, bus.precision, bus.is_signed, er, ef);
        q_r.push_back(er); q_f.push_back(ef);
        nacc++; load_next = 1;
      end
    end
    n_tests++;
    if (outs != 3 || !gap_ok)
      begin n_fail++; $display("FAIL bp_stream: got %0d outputs back-to-back=%b want 3/1", outs, gap_ok); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_rand(); bus.in_valid = 1'b1;
    @(negedge clk);
    drive_rand();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got out_valid=%b want 1", bus.out_valid); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.result !== 64'h0 || bus.flag !== 8'h0 || bus.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_clear: got v=%b r=%h f=%h rdy=%b want 0/0/0/1",
                               bus.out_valid, bus.result, bus.flag, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.out_valid !== 1'b0) stale++;
      @(negedge clk);
    end
    n_tests++;
    if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d valid cycles want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
